// File: rtl/ase_pkg.sv
// Shared CCI-P/ASE types and constants used by the read scheduler.
package ase_pkg;

  localparam int CCIP_ADDR_WIDTH  = 42;
  localparam int CCIP_DATA_WIDTH  = 512;
  localparam int CCIP_MDATA_WIDTH = 16;

  localparam logic [3:0] ASE_RDLINE_S = 4'h4;
  localparam logic [3:0] ASE_RDLINE_I = 4'h6;

  typedef enum logic [1:0] {
    VcVa  = 2'b00,
    VcVl0 = 2'b01,
    VcVh0 = 2'b10,
    VcVh1 = 2'b11
  } ccip_vc_e;

  typedef struct packed {
    logic [1:0]                 vc;
    logic                       sop;
    logic                       rsvd0;
    logic [1:0]                 len;
    logic [3:0]                 reqtype;
    logic [5:0]                 rsvd1;
    logic [CCIP_ADDR_WIDTH-1:0] addr;
    logic [15:0]                mdata;
  } TxHdr_t;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hitmiss;
    logic        format;
    logic        rsvd0;
    logic [1:0]  clnum;
    logic [3:0]  resptype;
    logic [15:0] mdata;
  } RxHdr_t;

endpackage

// File: rtl/ccip_rd_scheduler_arb.sv
// Round-robin arbiter: pointer names the highest-priority requester and
// moves past the winner only when the grant is actually taken.
module ccip_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_next_ptr;

  always_comb begin
    logic [PtrW:0]   sum;
    logic [PtrW-1:0] idx;
    logic            found;
    o_grant    = '0;
    w_next_ptr = r_ptr;
    found      = 1'b0;
    sum        = '0;
    idx        = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      sum = {1'b0, r_ptr} + (PtrW+1)'(k);
      if (sum >= (PtrW+1)'(NUM_REQ)) sum = sum - (PtrW+1)'(NUM_REQ);
      idx = sum[PtrW-1:0];
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        w_next_ptr   = (idx == PtrW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/ccip_rd_scheduler.sv
// Shares the C0 Tx read channel among NUM_REQ requesters, allocates mdata
// tags from a free pool and steers C0 Rx responses back to their owner.
module ccip_rd_scheduler
  import ase_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TAG_WIDTH = 6
) (
  input  logic                                    clk,
  input  logic                                    SoftReset_n,
  input  logic [1:0]                              cfg_vc,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ-1:0][CCIP_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]                      req_inval,
  output logic [NUM_REQ-1:0]                      req_ready,
  output TxHdr_t                                  C0TxHdr,
  output logic                                    C0TxRdValid,
  input  logic                                    C0TxAlmFull,
  input  RxHdr_t                                  C0RxHdr,
  input  logic                                    C0RxRdValid,
  input  logic [CCIP_DATA_WIDTH-1:0]              C0RxData,
  output logic [NUM_REQ-1:0]                      rsp_valid,
  output logic [CCIP_DATA_WIDTH-1:0]              rsp_data,
  output logic [TAG_WIDTH:0]                      outstanding,
  output logic                                    err_spurious
);

  localparam int unsigned PoolSize = 2 ** TAG_WIDTH;
  localparam int unsigned IdxW     = $clog2(NUM_REQ);

  logic [PoolSize-1:0]        r_free;
  logic [IdxW-1:0]            r_owner [PoolSize];
  logic [TAG_WIDTH:0]         r_cnt;
  logic                       r_err;
  logic                       r_txv;
  TxHdr_t                     r_hdr;
  logic [NUM_REQ-1:0]         r_rspv;
  logic [CCIP_DATA_WIDTH-1:0] r_rspd;

  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_issue;
  logic [TAG_WIDTH-1:0] w_alloc_tag;
  logic [IdxW-1:0]      w_gnt_idx;
  TxHdr_t               w_hdr;
  logic [TAG_WIDTH-1:0] w_rsp_tag;
  logic                 w_rsp_hit;
  logic                 w_spurious;
  logic [PoolSize-1:0]  w_alloc_mask;
  logic [PoolSize-1:0]  w_rel_mask;
  logic                 w_unused;

  assign w_issue = (|req_valid) && (|r_free) && !C0TxAlmFull;

  ccip_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_clk     (clk),
    .i_rst_n   (SoftReset_n),
    .i_req     (req_valid),
    .i_advance (w_issue),
    .o_grant   (w_grant)
  );

  assign req_ready = w_issue ? w_grant : '0;

  always_comb begin
    w_alloc_tag = '0;
    for (int i = int'(PoolSize) - 1; i >= 0; i--) begin
      if (r_free[i]) w_alloc_tag = TAG_WIDTH'(i);
    end
  end

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_grant[i]) w_gnt_idx = IdxW'(i);
    end
  end

  always_comb begin
    w_hdr         = '0;
    w_hdr.vc      = cfg_vc;
    w_hdr.reqtype = req_inval[w_gnt_idx] ? ASE_RDLINE_I : ASE_RDLINE_S;
    w_hdr.addr    = req_addr[w_gnt_idx];
    w_hdr.mdata   = CCIP_MDATA_WIDTH'(w_alloc_tag);
  end

  assign w_rsp_tag  = C0RxHdr.mdata[TAG_WIDTH-1:0];
  assign w_rsp_hit  = C0RxRdValid && !r_free[w_rsp_tag];
  assign w_spurious = C0RxRdValid && r_free[w_rsp_tag];

  // Allocated tag is free and a hit tag is busy, so the two masks never overlap.
  assign w_alloc_mask = w_issue ? (PoolSize'(1) << w_alloc_tag) : '0;
  assign w_rel_mask   = w_rsp_hit ? (PoolSize'(1) << w_rsp_tag) : '0;

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      r_free <= '1;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_txv  <= 1'b0;
      r_hdr  <= '0;
      r_rspv <= '0;
      r_rspd <= '0;
      for (int i = 0; i < int'(PoolSize); i++) r_owner[i] <= '0;
    end else begin
      r_free <= (r_free & ~w_alloc_mask) | w_rel_mask;
      r_txv  <= w_issue;
      if (w_issue) begin
        r_owner[w_alloc_tag] <= w_gnt_idx;
        r_hdr                <= w_hdr;
      end
      r_rspv <= w_rsp_hit ? (NUM_REQ'(1) << r_owner[w_rsp_tag]) : '0;
      if (w_rsp_hit) r_rspd <= C0RxData;
      if (w_spurious) r_err <= 1'b1;
      r_cnt <= r_cnt + (TAG_WIDTH+1)'(w_issue) - (TAG_WIDTH+1)'(w_rsp_hit);
    end
  end

  assign C0TxRdValid  = r_txv;
  assign C0TxHdr      = r_hdr;
  assign rsp_valid    = r_rspv;
  assign rsp_data     = r_rspd;
  assign outstanding  = r_cnt;
  assign err_spurious = r_err;

  assign w_unused = ^C0RxHdr;

endmodule

// File: tb/tb_ccip_rd_scheduler.sv
// Directed and randomized bench for ccip_rd_scheduler against a tag-pool model.
module tb_ccip_rd_scheduler;
  import ase_pkg::*;

  localparam int NR   = 4;
  localparam int TW   = 6;
  localparam int POOL = 64;

  logic                              clk = 1'b0;
  logic                              SoftReset_n;
  logic [1:0]                        cfg_vc;
  logic [NR-1:0]                     req_valid;
  logic [NR-1:0][CCIP_ADDR_WIDTH-1:0] req_addr;
  logic [NR-1:0]                     req_inval;
  logic [NR-1:0]                     req_ready;
  TxHdr_t                            C0TxHdr;
  logic                              C0TxRdValid;
  logic                              C0TxAlmFull;
  RxHdr_t                            C0RxHdr;
  logic                              C0RxRdValid;
  logic [CCIP_DATA_WIDTH-1:0]        C0RxData;
  logic [NR-1:0]                     rsp_valid;
  logic [CCIP_DATA_WIDTH-1:0]        rsp_data;
  logic [TW:0]                       outstanding;
  logic                              err_spurious;

  int checks = 0;
  int errors = 0;

  // Reference model: set of free tags, owner per tag, last winner, counters.
  bit            m_free [POOL];
  int            m_owner[POOL];
  int            m_last;
  int            m_cnt;
  bit            m_err;
  bit            e_txv;
  TxHdr_t        e_hdr;
  logic [NR-1:0] e_rspv;
  logic [511:0]  e_rspd;

  always #5 clk = ~clk;

  ccip_rd_scheduler #(
    .NUM_REQ   (NR),
    .TAG_WIDTH (TW)
  ) dut (
    .clk          (clk),
    .SoftReset_n  (SoftReset_n),
    .cfg_vc       (cfg_vc),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_inval    (req_inval),
    .req_ready    (req_ready),
    .C0TxHdr      (C0TxHdr),
    .C0TxRdValid  (C0TxRdValid),
    .C0TxAlmFull  (C0TxAlmFull),
    .C0RxHdr      (C0RxHdr),
    .C0RxRdValid  (C0RxRdValid),
    .C0RxData     (C0RxData),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .outstanding  (outstanding),
    .err_spurious (err_spurious)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req_valid   = '0;
    req_inval   = '0;
    req_addr    = '0;
    C0TxAlmFull = 1'b0;
    C0RxRdValid = 1'b0;
    C0RxHdr     = '0;
    C0RxData    = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < POOL; i++) begin
      m_free[i]  = 1'b1;
      m_owner[i] = 0;
    end
    m_last = NR - 1;
    m_cnt  = 0;
    m_err  = 1'b0;
    e_txv  = 1'b0;
    e_hdr  = '0;
    e_rspv = '0;
    e_rspd = '0;
  endtask

  task automatic do_reset();
    idle();
    SoftReset_n = 1'b0;
    #2;
    model_reset();
    chk("rst_txvalid", C0TxRdValid, 0);
    chk("rst_txhdr", C0TxHdr, 0);
    chk("rst_rspvalid", rsp_valid, 0);
    chk("rst_rspdata", rsp_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clk);
    SoftReset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: check req_ready for the current inputs, advance the model, then
  // check the registered outputs just after the edge.
  task automatic step();
    int  t;
    int  g;
    int  rt;
    bit  hit;
    bit  spur;
    logic [NR-1:0] er;
    #1;
    t = -1;
    for (int i = 0; i < POOL; i++) if (m_free[i] && t < 0) t = i;
    g = -1;
    if (req_valid != 0 && t >= 0 && !C0TxAlmFull) begin
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (m_last + k) % NR;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    er = (g >= 0) ? (NR'(1) << g) : '0;
    chk("req_ready", req_ready, er);
    rt   = int'(C0RxHdr.mdata[TW-1:0]);
    hit  = C0RxRdValid && !m_free[rt];
    spur = C0RxRdValid && m_free[rt];
    e_txv = (g >= 0);
    if (g >= 0) begin
      m_free[t]  = 1'b0;
      m_owner[t] = g;
      m_last     = g;
      m_cnt++;
      e_hdr         = '0;
      e_hdr.vc      = cfg_vc;
      e_hdr.reqtype = req_inval[g] ? 4'h6 : 4'h4;
      e_hdr.addr    = req_addr[g];
      e_hdr.mdata   = 16'(t);
    end
    if (hit) begin
      e_rspv     = NR'(1) << m_owner[rt];
      e_rspd     = C0RxData;
      m_free[rt] = 1'b1;
      m_cnt--;
    end else begin
      e_rspv = '0;
    end
    if (spur) m_err = 1'b1;
    @(posedge clk);
    #1;
    chk("tx_valid", C0TxRdValid, e_txv);
    if (e_txv) chk("tx_hdr", C0TxHdr, e_hdr);
    chk("rsp_valid", rsp_valid, e_rspv);
    if (e_rspv != 0) chk("rsp_data", rsp_data, e_rspd);
    chk("outstanding", outstanding, m_cnt);
    chk("err_spurious", err_spurious, m_err);
  endtask

  task automatic rand_drive();
    int r;
    int off;
    int t;
    req_valid   = NR'($urandom);
    req_inval   = NR'($urandom);
    for (int i = 0; i < NR; i++) req_addr[i] = 42'({$urandom, $urandom});
    C0TxAlmFull = ($urandom_range(0, 9) < 2);
    cfg_vc      = 2'($urandom);
    C0RxRdValid = 1'b0;
    C0RxHdr     = '0;
    C0RxData    = {16{$urandom}};
    r = $urandom_range(0, 99);
    if (r < 65) begin
      off = $urandom_range(0, POOL - 1);
      t   = -1;
      for (int k = 0; k < POOL; k++) begin
        if (t < 0 && !m_free[(off + k) % POOL]) t = (off + k) % POOL;
      end
      if (t >= 0) begin
        C0RxRdValid   = 1'b1;
        C0RxHdr.mdata = {10'($urandom), 6'(t)};
      end
    end else if (r < 70) begin
      C0RxRdValid   = 1'b1;
      C0RxHdr.mdata = 16'($urandom);
    end
  endtask

  initial begin
    SoftReset_n = 1'b1;
    cfg_vc      = '0;
    idle();
    #2;
    do_reset();

    // Single request from requester 0, then its response.
    cfg_vc      = 2'b01;
    req_valid   = 4'b0001;
    req_addr[0] = 42'h100;
    step();
    chk("t1_reqtype", C0TxHdr.reqtype, 4'h4);
    chk("t1_vc", C0TxHdr.vc, 2'b01);
    chk("t1_mdata", C0TxHdr.mdata, 0);
    chk("t1_addr", C0TxHdr.addr, 42'h100);
    req_valid   = '0;
    C0RxRdValid = 1'b1;
    C0RxHdr     = '0;
    C0RxData    = {16{32'hdeadbeef}};
    step();
    C0RxRdValid = 1'b0;
    chk("t1_rsp", rsp_valid, 4'b0001);
    chk("t1_rspdata", rsp_data, {16{32'hdeadbeef}});
    chk("t1_out", outstanding, 0);

    // All requesters valid: rotation 0,1,2,3,0 with tags 0..4.
    do_reset();
    req_valid = 4'hf;
    for (int i = 0; i < NR; i++) req_addr[i] = 42'(32'h1000 * (i + 1));
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_grant", req_ready, NR'(1) << (k % 4));
      step();
      chk("t2_mdata", C0TxHdr.mdata, k);
    end

    // Exhaust the pool from requester 1, free tag 2, check it is reused.
    do_reset();
    req_valid = 4'b0010;
    repeat (POOL) step();
    #1;
    chk("t3_ready_full", req_ready, 0);
    chk("t3_out_full", outstanding, POOL);
    C0RxRdValid   = 1'b1;
    C0RxHdr.mdata = 16'd2;
    step();
    C0RxRdValid = 1'b0;
    chk("t3_rsp_owner", rsp_valid, 4'b0010);
    step();
    chk("t3_reuse_mdata", C0TxHdr.mdata, 2);

    // AlmFull blocks issue for five cycles, issue resumes when it drops.
    do_reset();
    req_valid   = 4'hf;
    C0TxAlmFull = 1'b1;
    repeat (5) begin
      #1;
      chk("t4_stall", req_ready, 0);
      step();
    end
    C0TxAlmFull = 1'b0;
    #1;
    chk("t4_resume", req_ready, 4'b0001);
    step();

    // Response to a free tag is dropped and latches the sticky error.
    do_reset();
    C0RxRdValid   = 1'b1;
    C0RxHdr.mdata = 16'd7;
    step();
    C0RxRdValid = 1'b0;
    chk("t5_norsp", rsp_valid, 0);
    chk("t5_err", err_spurious, 1);
    repeat (3) step();
    chk("t5_sticky", err_spurious, 1);

    // Randomized traffic with a reset in the middle.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rand_drive();
      if (c == 300) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
